// File: rtl/tmnt_pal_pkg.sv
// Shared definitions for the palette RAM arbiter: bus width defaults and the
// CPU-side FSM state encoding.
package tmnt_pal_pkg;

    localparam int PAL_AW = 11;
    localparam int PAL_DW = 16;

    // Encoding is fixed so existing netlists and probes keep their meaning.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

endpackage

// File: rtl/pal_arbiter.sv
// Palette RAM arbiter: video fetches own every pixel slot, the CPU gets the
// RAM only in ACCESS on non-video cycles, with a simple NCS/NDTACK handshake.
module pal_arbiter
    import tmnt_pal_pkg::*;
#(
    parameter int AW = PAL_AW,
    parameter int DW = PAL_DW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          VID_CE,
    input  logic [AW-1:0] VID_CD,
    output logic [DW-1:0] VID_COL,
    output logic          VID_VALID,
    input  logic          CPU_NCS,
    input  logic          CPU_NREAD,
    input  logic          CPU_NUWR,
    input  logic          CPU_NLWR,
    input  logic [AW-1:0] CPU_A,
    input  logic [DW-1:0] CPU_DIN,
    output logic [DW-1:0] CPU_DOUT,
    output logic          CPU_NDTACK,
    output logic [AW-1:0] PAL_ADDR,
    output logic          PAL_WE_H,
    output logic          PAL_WE_L,
    output logic [DW-1:0] PAL_WDATA,
    input  logic [DW-1:0] PAL_Q
);

    logic [1:0]    state;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic          lat_we_h;
    logic          lat_we_l;
    logic          vid_pending;
    logic          cpu_req;
    logic          lat_write;
    logic          cpu_owns;

    assign cpu_req   = !CPU_NCS && (!CPU_NREAD || !CPU_NUWR || !CPU_NLWR);
    assign lat_write = lat_we_h || lat_we_l;

    // Reset gates ownership so an aborted write never reaches the RAM.
    assign cpu_owns   = (state == ST_ACCESS) && !VID_CE && !reset;
    assign PAL_ADDR   = cpu_owns ? lat_addr : VID_CD;
    assign PAL_WE_H   = cpu_owns && lat_we_h;
    assign PAL_WE_L   = cpu_owns && lat_we_l;
    assign PAL_WDATA  = lat_data;
    assign CPU_NDTACK = reset || (state != ST_ACK);

    // Video path: RAM data appears one cycle after the slot and is captured then.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_pending <= 1'b0;
            VID_VALID   <= 1'b0;
            VID_COL     <= '0;
        end else begin
            vid_pending <= VID_CE;
            VID_VALID   <= vid_pending;
            if (vid_pending) begin
                VID_COL <= PAL_Q;
            end
        end
    end

    // CPU FSM; a write strobe alongside the read strobe makes the access a write.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            lat_we_h <= 1'b0;
            lat_we_l <= 1'b0;
            CPU_DOUT <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        lat_addr <= CPU_A;
                        lat_data <= CPU_DIN;
                        lat_we_h <= !CPU_NUWR;
                        lat_we_l <= !CPU_NLWR;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!VID_CE) begin
                        state <= lat_write ? ST_ACK : ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    CPU_DOUT <= PAL_Q;
                    state    <= ST_ACK;
                end
                ST_ACK: begin
                    if (CPU_NCS) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pal_arbiter.sv
// Randomised scoreboard bench for pal_arbiter with a behavioural palette
// memory model and separate monitors for video, RAM writes and CPU acks.
module tb_pal_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        VID_CE;
    logic [10:0] VID_CD;
    logic [15:0] VID_COL;
    logic        VID_VALID;
    logic        CPU_NCS;
    logic        CPU_NREAD;
    logic        CPU_NUWR;
    logic        CPU_NLWR;
    logic [10:0] CPU_A;
    logic [15:0] CPU_DIN;
    logic [15:0] CPU_DOUT;
    logic        CPU_NDTACK;
    logic [10:0] PAL_ADDR;
    logic        PAL_WE_H;
    logic        PAL_WE_L;
    logic [15:0] PAL_WDATA;
    logic [15:0] PAL_Q;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
        logic        we_h;
        logic        we_l;
    } wr_t;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } ack_t;

    typedef struct {
        logic [15:0] col;
        int          due;
    } vid_t;

    wr_t         wr_q[$];
    ack_t        ack_q[$];
    vid_t        vid_q[$];
    logic [15:0] ref_mem [0:2047];
    logic [15:0] ram [0:2047];
    bit          preloaded;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          vid_mode = 0;
    logic        dir_ce = 1'b0;
    logic [10:0] dir_cd = '0;

    pal_arbiter #(.AW(11), .DW(16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .VID_CE(VID_CE), .VID_CD(VID_CD), .VID_COL(VID_COL), .VID_VALID(VID_VALID),
        .CPU_NCS(CPU_NCS), .CPU_NREAD(CPU_NREAD), .CPU_NUWR(CPU_NUWR), .CPU_NLWR(CPU_NLWR),
        .CPU_A(CPU_A), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .CPU_NDTACK(CPU_NDTACK),
        .PAL_ADDR(PAL_ADDR), .PAL_WE_H(PAL_WE_H), .PAL_WE_L(PAL_WE_L),
        .PAL_WDATA(PAL_WDATA), .PAL_Q(PAL_Q)
    );

    initial forever #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input int i);
        logic [31:0] p;
        p = i * 32'd40503;
        if (i == 2047) return 16'h1234;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    // Palette RAM: byte-lane writes, registered read with one-cycle latency.
    always @(posedge clk_sys) begin
        if (!preloaded) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_word(i);
            preloaded <= 1'b1;
        end else begin
            if (PAL_WE_H) ram[PAL_ADDR][15:8] <= PAL_WDATA[15:8];
            if (PAL_WE_L) ram[PAL_ADDR][7:0]  <= PAL_WDATA[7:0];
        end
        PAL_Q <= ram[PAL_ADDR];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Video slot driver; mode 3 replays values set by the directed tests.
    initial begin
        VID_CE = 1'b0;
        VID_CD = '0;
        forever begin
            @(posedge clk_sys);
            #2;
            case (vid_mode)
                1: begin
                    VID_CE = 1'($urandom_range(0, 1));
                    VID_CD = 11'h700 | 11'($urandom_range(0, 255));
                end
                2: begin
                    VID_CE = ~VID_CE;
                    VID_CD = 11'h7FF;
                end
                3: begin
                    VID_CE = dir_ce;
                    VID_CD = dir_cd;
                end
                default: VID_CE = 1'b0;
            endcase
        end
    end

    initial forever begin : video_monitor
        vid_t v;
        @(negedge clk_sys);
        if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
            v = vid_q.pop_front();
            check_output("vid_valid", VID_VALID, 1);
            check_output("vid_col", VID_COL, v.col);
        end else begin
            check_output("vid_valid_idle", VID_VALID, 0);
        end
        if (VID_CE === 1'b1 && reset === 1'b0) begin
            v.col = ref_mem[VID_CD];
            v.due = cyc + 2;
            vid_q.push_back(v);
        end
    end

    initial forever begin : write_monitor
        wr_t w;
        @(negedge clk_sys);
        if (PAL_WE_H !== 1'b0 || PAL_WE_L !== 1'b0) begin
            if (wr_q.size() == 0) begin
                check_output("unexpected_write", {PAL_WE_H, PAL_WE_L}, 0);
            end else begin
                w = wr_q.pop_front();
                check_output("wr_addr", PAL_ADDR, w.addr);
                check_output("wr_data", PAL_WDATA, w.data);
                check_output("wr_we_h", PAL_WE_H, w.we_h);
                check_output("wr_we_l", PAL_WE_L, w.we_l);
                check_output("wr_no_video", VID_CE, 0);
            end
        end
    end

    initial begin : ack_monitor
        logic [15:0] exp_last;
        logic        prev_ndtack;
        ack_t        a;
        exp_last    = '0;
        prev_ndtack = 1'b1;
        forever begin
            @(negedge clk_sys);
            if (reset === 1'b1) begin
                exp_last    = '0;
                prev_ndtack = 1'b1;
            end else begin
                if (CPU_NDTACK === 1'b0 && prev_ndtack) begin
                    if (ack_q.size() == 0) begin
                        check_output("unexpected_ack", CPU_NDTACK, 1);
                    end else begin
                        a = ack_q.pop_front();
                        if (a.is_read) exp_last = a.data;
                        check_output("cpu_dout", CPU_DOUT, exp_last);
                    end
                end
                prev_ndtack = CPU_NDTACK;
            end
        end
    end

    // Drives a request and records what the RAM and the CPU should see.
    task automatic drive_request(input logic [10:0] addr, input logic [15:0] data,
                                 input logic nuwr, input logic nlwr, input logic nread);
        wr_t  w;
        ack_t a;
        CPU_NCS   = 1'b0;
        CPU_A     = addr;
        CPU_DIN   = data;
        CPU_NUWR  = nuwr;
        CPU_NLWR  = nlwr;
        CPU_NREAD = nread;
        if (!nuwr || !nlwr) begin
            w.addr = addr;
            w.data = data;
            w.we_h = !nuwr;
            w.we_l = !nlwr;
            wr_q.push_back(w);
            if (!nuwr) ref_mem[addr][15:8] = data[15:8];
            if (!nlwr) ref_mem[addr][7:0]  = data[7:0];
            a.is_read = 1'b0;
            a.data    = '0;
        end else begin
            a.is_read = 1'b1;
            a.data    = ref_mem[addr];
        end
        ack_q.push_back(a);
    endtask

    task automatic complete_request(input int hold, input int exp_lat);
        int k;
        k = 0;
        @(negedge clk_sys);
        while (CPU_NDTACK !== 1'b0 && k < 60) begin
            @(negedge clk_sys);
            k++;
        end
        if (k >= 60) check_output("ack_timeout", CPU_NDTACK, 0);
        else if (exp_lat >= 0) check_output("ack_latency", k, exp_lat);
        repeat (hold) begin
            @(negedge clk_sys);
            check_output("ack_held", CPU_NDTACK, 0);
        end
        @(posedge clk_sys);
        #1;
        CPU_NCS   = 1'b1;
        CPU_NREAD = 1'b1;
        CPU_NUWR  = 1'b1;
        CPU_NLWR  = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_output("ack_release", CPU_NDTACK, 1);
    endtask

    task automatic apply_stimulus(input logic [10:0] addr, input logic [15:0] data,
                                  input logic nuwr, input logic nlwr, input logic nread,
                                  input int hold, input int exp_lat);
        @(posedge clk_sys);
        #1;
        drive_request(addr, data, nuwr, nlwr, nread);
        complete_request(hold, exp_lat);
    endtask

    task automatic random_traffic(input int count);
        logic [10:0] addr;
        logic [15:0] data;
        int          kind;
        int          lat_w;
        int          lat_r;
        logic        rd_too;
        for (int n = 0; n < count; n++) begin
            addr   = 11'($urandom_range(0, 11'h6FF));
            data   = 16'($urandom);
            kind   = $urandom_range(0, 3);
            rd_too = 1'($urandom_range(0, 1));
            lat_w  = (vid_mode == 0) ? 2 : -1;
            lat_r  = (vid_mode == 0) ? 3 : -1;
            case (kind)
                0: apply_stimulus(addr, data, 1'b1, 1'b1, 1'b0, $urandom_range(0, 2), lat_r);
                1: apply_stimulus(addr, data, 1'b0, 1'b0, !rd_too, $urandom_range(0, 2), lat_w);
                2: apply_stimulus(addr, data, 1'b0, 1'b1, !rd_too, $urandom_range(0, 2), lat_w);
                default: apply_stimulus(addr, data, 1'b1, 1'b0, !rd_too, $urandom_range(0, 2), lat_w);
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
        reset     = 1'b1;
        CPU_NCS   = 1'b1;
        CPU_NREAD = 1'b1;
        CPU_NUWR  = 1'b1;
        CPU_NLWR  = 1'b1;
        CPU_A     = '0;
        CPU_DIN   = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_output("rst_ndtack", CPU_NDTACK, 1);
        check_output("rst_dout", CPU_DOUT, 0);
        check_output("rst_vid_col", VID_COL, 0);
        check_output("rst_we", {PAL_WE_H, PAL_WE_L}, 0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;

        apply_stimulus(11'h123, 16'h7FFF, 1'b0, 1'b0, 1'b1, 0, 2);
        apply_stimulus(11'h010, 16'h00AA, 1'b1, 1'b0, 1'b1, 0, 2);
        apply_stimulus(11'h010, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 3);
        apply_stimulus(11'h200, 16'hC3C3, 1'b0, 1'b1, 1'b0, 0, 2);
        apply_stimulus(11'h200, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 3);
        apply_stimulus(11'h321, 16'h4444, 1'b0, 1'b0, 1'b1, 20, 2);

        // Read held off by three consecutive video slots.
        vid_mode = 3;
        dir_ce   = 1'b0;
        dir_cd   = 11'h7A5;
        @(posedge clk_sys);
        #1;
        drive_request(11'h0AB, 16'h0000, 1'b1, 1'b1, 1'b0);
        @(posedge clk_sys);
        #1;
        dir_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            check_output("vid_owns_addr", PAL_ADDR, 11'h7A5);
            @(posedge clk_sys);
            #1;
            if (i == 2) dir_ce = 1'b0;
        end
        @(negedge clk_sys);
        check_output("cpu_owns_addr", PAL_ADDR, 11'h0AB);
        complete_request(0, -1);
        vid_mode = 0;
        repeat (4) @(posedge clk_sys);

        // Reset in the ACCESS cycle of a write, with NCS held through it.
        @(posedge clk_sys);
        #1;
        CPU_NCS  = 1'b0;
        CPU_A    = 11'h055;
        CPU_DIN  = 16'hBEEF;
        CPU_NUWR = 1'b0;
        CPU_NLWR = 1'b0;
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        @(negedge clk_sys);
        check_output("rst_abort_we", {PAL_WE_H, PAL_WE_L}, 0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check_output("rst_abort_ndtack", CPU_NDTACK, 1);
        check_output("rst_abort_dout", CPU_DOUT, 0);
        drive_request(11'h055, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        complete_request(0, -1);
        apply_stimulus(11'h055, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 3);

        vid_mode = 2;
        random_traffic(40);
        vid_mode = 1;
        random_traffic(80);
        vid_mode = 0;
        random_traffic(20);
        repeat (6) @(posedge clk_sys);
        @(negedge clk_sys);
        check_output("wr_q_drained", wr_q.size(), 0);
        check_output("ack_q_drained", ack_q.size(), 0);
        check_output("vid_q_drained", vid_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pal_arbiter.md
PAL_ARBITER -- requirements
Module: pal_arbiter

Interface
REQ-001 Parameter AW, 11, palette RAM word-address width.
REQ-002 Parameter DW, 16, palette RAM data width (two byte lanes).
REQ-003 clk_sys  in  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 VID_CE  in  1  pixel slot strobe (one clk_sys cycle per pixel).
REQ-006 VID_CD  in  AW  video palette index for the current slot.
REQ-007 VID_COL  out  DW  palette word for the last video slot.
REQ-008 VID_VALID  out  1  one-cycle pulse when VID_COL updates.
REQ-009 CPU_NCS  in  1  palette chip select, active-low.
REQ-010 CPU_NREAD  in  1  read strobe, active-low.
REQ-011 CPU_NUWR / CPU_NLWR  in  1 each  upper/lower byte write strobes, active-low.
REQ-012 CPU_A  in  AW  CPU word address.
REQ-013 CPU_DIN  in  DW  CPU write data.
REQ-014 CPU_DOUT  out  DW  CPU read data, held until the next read completes.
REQ-015 CPU_NDTACK  out  1  transfer acknowledge, active-low.
REQ-016 PAL_ADDR  out  AW  RAM address (combinational from owner).
REQ-017 PAL_WE_H / PAL_WE_L  out  1 each  RAM byte write enables.
REQ-018 PAL_WDATA  out  DW  RAM write data.
REQ-019 PAL_Q  in  DW  RAM read data, one-cycle synchronous latency.

Function
- RAM ownership, per cycle
REQ-020 A cycle with VID_CE=1 SHALL be owned by video: PAL_ADDR=VID_CD, PAL_WE_H=PAL_WE_L=0.
REQ-021 The cycle after a video slot SHALL latch PAL_Q into VID_COL and pulse VID_VALID.
REQ-022 The CPU SHALL own the RAM only in state ACCESS with VID_CE=0; otherwise PAL_ADDR=VID_CD and no write enable.
- CPU FSM: states IDLE, ACCESS, RDWAIT, ACK
REQ-023 IDLE->ACCESS when CPU_NCS=0 and any strobe is low; CPU_A, CPU_DIN, strobes latched on entry.
REQ-024 Read plus any write strobe low together SHALL be a write; the read is dropped.
REQ-025 ACCESS with VID_CE=1 SHALL hold (video wins, CPU waits one slot); there is no timeout.
REQ-026 ACCESS with VID_CE=0: PAL_ADDR=latched address; on a write, PAL_WE_H=~NUWR, PAL_WE_L=~NLWR, PAL_WDATA=latched data, go to ACK; on a read, go to RDWAIT.
REQ-027 RDWAIT SHALL load CPU_DOUT from PAL_Q (one cycle) and go to ACK, regardless of VID_CE.
REQ-028 ACK SHALL drive CPU_NDTACK=0 until CPU_NCS=1 is sampled, then NDTACK=1 and go to IDLE.
REQ-029 CPU_NDTACK SHALL be 1 in every state except ACK.
REQ-030 Exactly one RAM access per CPU_NCS assertion; holding CPU_NCS=0 in ACK SHALL NOT re-trigger.
REQ-031 Best-case latency: request sampled at t -> write in t+1, NDTACK low at t+2; read sampled at t -> NDTACK low at t+3.
REQ-032 Address and data SHALL be used unmodified (full AW-bit range, no wrap logic).

Reset
REQ-033 On reset: state IDLE, CPU_NDTACK=1, CPU_DOUT=0, VID_COL=0, VID_VALID=0, latches cleared, no write enable.
REQ-034 Reset mid-transfer SHALL abort it with no RAM write in the reset cycle; a held CPU_NCS=0 after reset SHALL start a new request.

Structure
REQ-035 Package tmnt_pal_pkg SHALL hold the FSM state encoding and the AW/DW defaults.
REQ-036 Single flat module, no sub-modules; the RAM stays external.

Verification
REQ-037 Write 0x7FFF (both strobes) to 0x123 with VID_CE=0 -> PAL_WE_H=PAL_WE_L=1 and PAL_ADDR=0x123 one cycle; NDTACK low next cycle, high after NCS=1.
REQ-038 Lower-byte write 0x00AA to 0x010 -> only PAL_WE_L=1; read-back of 0x010 returns 0xXXAA with the upper byte unchanged.
REQ-039 Read pending while VID_CE=1 for 3 cycles -> PAL_ADDR=VID_CD those cycles, CPU access in the 4th, correct CPU_DOUT, VID_COL unaffected.
REQ-040 VID_CE every 2nd cycle, VID_CD=0x7FF with RAM[0x7FF]=0x1234 -> VID_COL=0x1234 and VID_VALID pulse one cycle after each slot, including slots that interleave CPU accesses.
REQ-041 Assert reset in ACCESS of a write -> no write enable in that cycle; NDTACK=1; state IDLE; a new request completes normally.
REQ-042 CPU_NCS held 0 for 20 cycles after one write -> exactly one PAL_WE pulse and NDTACK held low until NCS rises.
